// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg
// Shared encodings for the EX stage: ALU operation codes, operand forward
// selects and multiplier FSM states. Also holds the forward-priority helper
// that is used for both ALU operands.
package execute_stage_pkg;

  // ALUCtrl encodings. Codes not listed here produce a zero result.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  // Source of a forwarded operand.
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_WB    = 2'b10
  } fwd_sel_e;

  // Sequential multiplier states.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mult_state_e;

  // Pick the operand source for register src. The EX/MEM result is younger
  // than the WB value, so it wins when both match. Register 0 is never
  // forwarded because it is hardwired to zero.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] src,
    input logic [4:0] exmem_dst,
    input logic       exmem_we,
    input logic [4:0] wb_dst,
    input logic       wb_we
  );
    fwd_sel_e sel;
    if (exmem_we && (exmem_dst != 5'd0) && (exmem_dst == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_we && (wb_dst != 5'd0) && (wb_dst == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/execute_stage_mult.sv
// mult_seq_unit
// Radix-2 shift-add unsigned multiplier producing a 2*WIDTH-bit product
// into HI/LO. One iteration per cycle; MULT_CYCLES must equal WIDTH.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : accepted only in IDLE; latches a and b
//   a, b     : multiplicand / multiplier
//   busy     : high while iterating (combinational from the state)
//   hi, lo   : upper / lower product halves, updated on the last iteration
module mult_seq_unit
  import execute_stage_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MULT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mult_state_e          r_state;
  mult_state_e          w_state_next;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 w_last;

  assign w_last = (r_count == CNT_LAST);
  assign busy   = (r_state == BUSY);
  assign hi     = r_hi;
  assign lo     = r_lo;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; a start during BUSY is ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = BUSY;
        end else begin
          w_state_next = IDLE;
        end
      end
      BUSY: begin
        if (w_last) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = BUSY;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Accumulator plus the current partial product.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = r_acc + r_mcand;
    end else begin
      w_acc_next = r_acc;
    end
  end

  // Iteration datapath. The final sum is written straight into HI/LO on
  // the BUSY->IDLE edge so an MFHI/MFLO in the next cycle sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CNT_ONE;
          if (w_last) begin
            r_hi <= w_acc_next[2*WIDTH-1:WIDTH];
            r_lo <= w_acc_next[WIDTH-1:0];
          end
        end
        default: begin
          r_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage
// EX stage of the 5-stage MIPS pipeline: operand forwarding, ALU, the
// sequential HI/LO multiplier and the EX/MEM pipeline register.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   readData1/readData2           : rs / rt values from ID/EX
//   signExtImm                    : sign-extended immediate
//   rs, rt, rd                    : register numbers
//   ALUCtrl, ALUSrc, RegDst       : ALU op, B-operand select, dest select
//   RegWrite/memWrite/memRead/memtoReg : controls carried to EX/MEM
//   multStart, mfhi, mflo         : MULTU / MFHI / MFLO in EX
//   wb_data, wb_dst, wb_RegWrite  : write-back bus for forwarding
//   out_ALU, memWriteData, regWriteDst, out_* : registered EX/MEM outputs
//   stall                         : multiplier busy, hold upstream stages
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  input  logic [WIDTH-1:0] signExtImm,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [2:0]       ALUCtrl,
  input  logic             ALUSrc,
  input  logic             RegDst,
  input  logic             RegWrite,
  input  logic             memWrite,
  input  logic             memRead,
  input  logic             memtoReg,
  input  logic             multStart,
  input  logic             mfhi,
  input  logic             mflo,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [4:0]       wb_dst,
  input  logic             wb_RegWrite,
  output logic [WIDTH-1:0] out_ALU,
  output logic [WIDTH-1:0] memWriteData,
  output logic [4:0]       regWriteDst,
  output logic             out_RegWrite,
  output logic             out_memWrite,
  output logic             out_memRead,
  output logic             out_memtoReg,
  output logic             stall
);

  logic [WIDTH-1:0] r_out_ALU;
  logic [WIDTH-1:0] r_memWriteData;
  logic [4:0]       r_regWriteDst;
  logic             r_out_RegWrite;
  logic             r_out_memWrite;
  logic             r_out_memRead;
  logic             r_out_memtoReg;

  fwd_sel_e         w_sel_a;
  fwd_sel_e         w_sel_b;
  logic [WIDTH-1:0] w_fwd_a;
  logic [WIDTH-1:0] w_fwd_b;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_result;
  logic             w_slt;
  logic             w_busy;
  logic             w_bubble;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  mult_seq_unit #(
    .WIDTH       (WIDTH),
    .MULT_CYCLES (MULT_CYCLES)
  ) u_mult (
    .clk   (clk),
    .rst   (rst),
    .start (multStart),
    .a     (w_fwd_a),
    .b     (w_fwd_b),
    .busy  (w_busy),
    .hi    (w_hi),
    .lo    (w_lo)
  );

  // Forward-source selection for both operands.
  always_comb begin
    w_sel_a = fwd_select(rs, r_regWriteDst, r_out_RegWrite, wb_dst, wb_RegWrite);
    w_sel_b = fwd_select(rt, r_regWriteDst, r_out_RegWrite, wb_dst, wb_RegWrite);
  end

  // Forwarding muxes.
  always_comb begin
    w_fwd_a = readData1;
    w_fwd_b = readData2;
    case (w_sel_a)
      FWD_EXMEM: w_fwd_a = r_out_ALU;
      FWD_WB:    w_fwd_a = wb_data;
      default:   w_fwd_a = readData1;
    endcase
    case (w_sel_b)
      FWD_EXMEM: w_fwd_b = r_out_ALU;
      FWD_WB:    w_fwd_b = wb_data;
      default:   w_fwd_b = readData2;
    endcase
  end

  assign w_b_op = ALUSrc ? signExtImm : w_fwd_b;
  assign w_slt  = ($signed(w_fwd_a) < $signed(w_b_op));

  // ALU; add/sub wrap without trapping.
  always_comb begin
    w_alu = '0;
    case (ALUCtrl)
      ALU_AND: w_alu = w_fwd_a & w_b_op;
      ALU_OR:  w_alu = w_fwd_a | w_b_op;
      ALU_ADD: w_alu = w_fwd_a + w_b_op;
      ALU_SUB: w_alu = w_fwd_a - w_b_op;
      ALU_SLT: w_alu = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_alu = '0;
    endcase
  end

  // Result select: HI/LO moves override the ALU.
  always_comb begin
    w_result = w_alu;
    if (mfhi) begin
      w_result = w_hi;
    end else if (mflo) begin
      w_result = w_lo;
    end else begin
      w_result = w_alu;
    end
  end

  // MULTU itself and every stalled cycle leave a bubble in EX/MEM.
  assign w_bubble = w_busy | multStart;

  // EX/MEM pipeline register, loaded every cycle.
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_out_ALU      <= '0;
      r_memWriteData <= '0;
      r_regWriteDst  <= 5'd0;
      r_out_RegWrite <= 1'b0;
      r_out_memWrite <= 1'b0;
      r_out_memRead  <= 1'b0;
      r_out_memtoReg <= 1'b0;
    end else begin
      r_out_ALU      <= w_result;
      r_memWriteData <= w_fwd_b;
      r_regWriteDst  <= RegDst ? rd : rt;
      r_out_RegWrite <= RegWrite;
      r_out_memWrite <= memWrite;
      r_out_memRead  <= memRead;
      r_out_memtoReg <= memtoReg;
    end
  end

  assign out_ALU      = r_out_ALU;
  assign memWriteData = r_memWriteData;
  assign regWriteDst  = r_regWriteDst;
  assign out_RegWrite = r_out_RegWrite;
  assign out_memWrite = r_out_memWrite;
  assign out_memRead  = r_out_memRead;
  assign out_memtoReg = r_out_memtoReg;
  assign stall        = w_busy;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline.
- Takes ID/EX operands and controls, resolves operand forwarding, runs the ALU and a sequential 32x32 unsigned multiplier (HI/LO), and registers results into the EX/MEM boundary.
- Its registered outputs drive the MEM/WB stage directly: ALU result, store data, write destination, RegWrite, memWrite, memRead, memtoReg.
- Asserts stall to the hazard logic while the multiplier is busy.

Parameters:
- WIDTH, 32, datapath width. HI/LO are each WIDTH bits.
- MULT_CYCLES, 32, multiplier iterations. Must equal WIDTH (radix-2 shift-add).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- readData1  in  32  rs value from ID/EX
- readData2  in  32  rt value from ID/EX
- signExtImm  in  32  sign-extended immediate
- rs, rt, rd  in  5 each  register numbers
- ALUCtrl  in  3  ALU operation
- ALUSrc  in  1  1: B operand = signExtImm
- RegDst  in  1  1: destination = rd, else rt
- RegWrite, memWrite, memRead, memtoReg  in  1 each  controls passed to EX/MEM
- multStart  in  1  MULTU instruction in EX
- mfhi, mflo  in  1 each  result = HI / LO
- wb_data  in  32  value written back by the WB stage
- wb_dst  in  5  WB destination
- wb_RegWrite  in  1  WB write enable
- out_ALU  out  32  registered result
- memWriteData  out  32  registered forwarded rt
- regWriteDst  out  5  registered destination
- out_RegWrite, out_memWrite, out_memRead, out_memtoReg  out  1 each  registered controls
- stall  out  1  hold IF/ID/ID-EX this cycle

Behaviour:
- Reset: all registered outputs = 0, HI = LO = 0, FSM = IDLE, stall = 0.
- Forwarding for A (rs), and identically for B (rt):
  - If out_RegWrite and regWriteDst != 0 and regWriteDst == rs, use out_ALU.
  - Else if wb_RegWrite and wb_dst != 0 and wb_dst == rs, use wb_data.
  - Else use readData1.
  - EX/MEM has priority over WB.
  - Load-use hazards are excluded by the upstream hazard unit. This block does not detect them.
- B operand to the ALU = ALUSrc ? signExtImm : forwarded rt.
- memWriteData = forwarded rt, never the immediate.
- ALUCtrl encoding:
  - 000 AND, 001 OR, 010 ADD, 110 SUB.
  - 111 SLT: signed; result 1 or 0, zero-extended.
  - Any other code gives result 0.
  - Add and sub wrap modulo 2^32. No overflow trap.
- Result select: mfhi → HI, mflo → LO, else ALU result.
- regWriteDst = RegDst ? rd : rt.
- Multiplier FSM:
  - IDLE: multStart=1 latches forwarded A and B, clears the accumulator, and goes to BUSY with count=0.
  - BUSY: each cycle, if multiplier LSB = 1 add the shifted multiplicand; shift multiplier right and multiplicand left; count++. At count == MULT_CYCLES-1, write {HI,LO} = 64-bit product and go to IDLE.
  - stall = (state == BUSY), combinational.
  - Total: stall is high exactly 32 cycles, starting the cycle after multStart is sampled.
- EX/MEM register:
  - Loads every cycle.
  - When stall=1, or when the current instruction is multStart, it loads a bubble: all four controls = 0, data = 0.
- While stall=1, upstream holds its inputs constant. multStart seen during BUSY is ignored; the held instruction re-presents after stall drops.
- mfhi/mflo issued directly after the multiplier finishes reads the new HI/LO, which are written on the same edge BUSY→IDLE.
- Reset mid-BUSY: the FSM returns to IDLE, HI/LO are cleared, and stall drops in the cycle after the reset edge.
- Simultaneous EX/MEM and WB match on the same register: EX/MEM wins.

Decomposition:
- Shared package:
  - ALUCtrl codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT).
  - Forward-select encoding (FWD_REG, FWD_EXMEM, FWD_WB).
  - Multiplier state encoding (IDLE, BUSY).
- One sub-module, mult_seq_unit. It contains the FSM, counter, HI and LO, and has ports clk, rst, start, a, b, busy, hi, lo. Forwarding and the ALU stay in execute_stage.

Test Plan:
- ADD, forwarding from EX/MEM:
  - Stimulus: readData1=5, readData2=7, ALUCtrl=010, RegWrite=1, RegDst=1, rd=3.
  - Next: rs=3, readData1=0, readData2=1, ALUCtrl=010.
  - Required: out_ALU=12, then 13.
- WB forwarding and priority:
  - Stimulus: wb_dst=4, wb_data=100, wb_RegWrite=1; rt=4, ALUSrc=0, ALUCtrl=110, readData1=150.
  - Required: out_ALU=50, memWriteData=100.
  - With regWriteDst=4 also set: EX/MEM value wins.
  - wb_dst=0: never forwarded.
- SLT signed: A=0xFFFFFFFF, B=1 → out_ALU=1. Swapped operands → 0.
- MULTU:
  - Stimulus: A=0xFFFFFFFF, B=2, multStart=1.
  - Required: stall high for exactly 32 cycles, with controls bubbled throughout. Afterwards mfhi gives 1 and mflo gives 0xFFFFFFFE.
- Reset mid-multiply: assert rst at BUSY cycle 10 → next cycle stall=0, HI=LO=0, all outputs 0.
- Wrap: ADD 0x7FFFFFFF+1 → 0x80000000, with no side effects.
